rr_switch: RTL and testbench

- Registered, arbitrated N-to-1 data switch for the CPU datapath; next generation of the combinational `switch`.
- Up to SIZE requesters present DATA_WIDTH words with a req/ack handshake.
- A round-robin arbiter picks one requester per cycle and loads its word into a single output register.
- The output register is drained with a valid/ready handshake. Used wherever several units share one bus: register file, ALU result and memory read return.

---
 rtl/rr_switch.sv | 65 ++++++
 tb/tb_rr_switch.sv | 137 +++++++++++++
 2 files changed

// File: rtl/rr_switch.sv
// rr_switch: registered round-robin N-to-1 switch with req/ack inputs and valid/ready output.
// Define RR_SWITCH_FORCE_EN to add force_en/force_sel static channel selection.
module rr_switch #(
  parameter int SIZE = 8,
  parameter int DATA_WIDTH = 16,
  parameter int SEL_WIDTH = $clog2(SIZE)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SIZE*DATA_WIDTH-1:0] data_in,
  input  logic [SIZE-1:0]            req,
  output logic [SIZE-1:0]            ack,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [SEL_WIDTH-1:0]       out_sel,
  output logic                       out_valid,
`ifdef RR_SWITCH_FORCE_EN
  input  logic                       force_en,
  input  logic [SEL_WIDTH-1:0]       force_sel,
`endif
  input  logic                       out_ready
);
  logic [SEL_WIDTH-1:0] ptr, g_rr, g, ptr_nxt;
  logic found, grant_ok, load, upd_ptr;
  always_comb begin
    found = 1'b0;
    g_rr = '0;
    for (int k = 0; k < SIZE; k++) begin
      if (!found && req[(int'(ptr) + k) % SIZE]) begin
        found = 1'b1;
        g_rr = SEL_WIDTH'((int'(ptr) + k) % SIZE);
      end
    end
  end
`ifdef RR_SWITCH_FORCE_EN
  assign grant_ok = force_en ? (int'(force_sel) < SIZE) && req[force_sel] : found;
  assign g = force_en ? force_sel : g_rr;
  assign upd_ptr = !force_en;
`else
  assign grant_ok = found;
  assign g = g_rr;
  assign upd_ptr = 1'b1;
`endif
  // reset gates load so ack stays low while reset is held
  assign load = reset && grant_ok && (!out_valid || out_ready);
  assign ptr_nxt = (int'(g) == SIZE - 1) ? '0 : g + 1'b1;
  always_comb begin
    ack = '0;
    if (load) ack[g] = 1'b1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      out_sel <= '0;
      out_valid <= 1'b0;
      ptr <= '0;
    end else if (load) begin
      data_out <= data_in[int'(g)*DATA_WIDTH +: DATA_WIDTH];
      out_sel <= g;
      out_valid <= 1'b1;
      if (upd_ptr) ptr <= ptr_nxt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_switch.sv
// tb_rr_switch: directed table-driven bench for rr_switch (SIZE=8, DATA_WIDTH=16).
module tb_rr_switch;
  localparam int SIZE = 8;
  localparam int DW = 16;
  localparam int SW = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [SIZE*DW-1:0] data_in;
  logic [SIZE-1:0] req = '0;
  logic [SIZE-1:0] ack;
  logic [DW-1:0] data_out;
  logic [SW-1:0] out_sel;
  logic out_valid;
  logic out_ready = 1'b0;
`ifdef RR_SWITCH_FORCE_EN
  logic force_en = 1'b0;
  logic [SW-1:0] force_sel = '0;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_switch #(.SIZE(SIZE), .DATA_WIDTH(DW)) dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .req(req),
    .ack(ack),
    .data_out(data_out),
    .out_sel(out_sel),
    .out_valid(out_valid),
`ifdef RR_SWITCH_FORCE_EN
    .force_en(force_en),
    .force_sel(force_sel),
`endif
    .out_ready(out_ready)
  );

  typedef struct {
    logic [7:0]  req;
    logic        rdy;
    logic [7:0]  ack;
    logic        valid;
    logic [2:0]  sel;
    logic [15:0] data;
  } vec_t;

  vec_t tbl[22];

  function automatic logic [15:0] word(input int i);
    return (i == 7) ? 16'h0108 : 16'((i + 1) * 16'h0110);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input string nm, input logic [7:0] r, input logic rdy, input logic [7:0] eack,
                      input logic ev, input logic [2:0] es, input logic [15:0] ed);
    req = r;
    out_ready = rdy;
    #1 chk({nm, ".ack"}, 32'(ack), 32'(eack));
    @(posedge clk);
    #1;
    chk({nm, ".valid"}, 32'(out_valid), 32'(ev));
    chk({nm, ".sel"}, 32'(out_sel), 32'(es));
    chk({nm, ".data"}, 32'(data_out), 32'(ed));
  endtask

  initial begin
    for (int i = 0; i < SIZE; i++) data_in[i*DW +: DW] = word(i);
    // fairness: all requesting, grants rotate 0..7 then 0
    for (int i = 0; i < 9; i++)
      tbl[i] = '{8'hFF, 1'b1, 8'(1 << (i % 8)), 1'b1, 3'(i % 8), word(i % 8)};
    // pointer moves to 2, then 7/1/7 wrap-and-skip
    tbl[9]  = '{8'h02, 1'b1, 8'h02, 1'b1, 3'd1, 16'h0220};
    tbl[10] = '{8'h82, 1'b1, 8'h80, 1'b1, 3'd7, 16'h0108};
    tbl[11] = '{8'h82, 1'b1, 8'h02, 1'b1, 3'd1, 16'h0220};
    tbl[12] = '{8'h82, 1'b1, 8'h80, 1'b1, 3'd7, 16'h0108};
    // drain to empty, then idle with ready low
    tbl[13] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd7, 16'h0108};
    tbl[14] = '{8'h00, 1'b0, 8'h00, 1'b0, 3'd7, 16'h0108};
    // backpressure: load ch2, stall 3 cycles, then drain+reload same cycle
    tbl[15] = '{8'h04, 1'b0, 8'h04, 1'b1, 3'd2, 16'h0330};
    tbl[16] = '{8'h0C, 1'b0, 8'h00, 1'b1, 3'd2, 16'h0330};
    tbl[17] = '{8'h0C, 1'b0, 8'h00, 1'b1, 3'd2, 16'h0330};
    tbl[18] = '{8'h0C, 1'b0, 8'h00, 1'b1, 3'd2, 16'h0330};
    tbl[19] = '{8'h0C, 1'b1, 8'h08, 1'b1, 3'd3, 16'h0440};
    tbl[20] = '{8'h00, 1'b0, 8'h00, 1'b1, 3'd3, 16'h0440};
    tbl[21] = '{8'h00, 1'b1, 8'h00, 1'b0, 3'd3, 16'h0440};

    req = 8'hFF;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ack", 32'(ack), 0);
    chk("rst.valid", 32'(out_valid), 0);
    chk("rst.data", 32'(data_out), 0);
    chk("rst.sel", 32'(out_sel), 0);
    reset = 1'b1;

    for (int i = 0; i < 22; i++)
      step($sformatf("vec%0d", i), tbl[i].req, tbl[i].rdy, tbl[i].ack, tbl[i].valid, tbl[i].sel, tbl[i].data);

    // reset mid-stall: pointer is 4, load ch5, stall, then async reset
    step("ms_load", 8'h20, 1'b0, 8'h20, 1'b1, 3'd5, 16'h0660);
    step("ms_stall", 8'h20, 1'b0, 8'h00, 1'b1, 3'd5, 16'h0660);
    reset = 1'b0;
    #1;
    chk("ms_rst.valid", 32'(out_valid), 0);
    chk("ms_rst.data", 32'(data_out), 0);
    chk("ms_rst.sel", 32'(out_sel), 0);
    chk("ms_rst.ack", 32'(ack), 0);
    #1 reset = 1'b1;
    step("restart", 8'h81, 1'b1, 8'h01, 1'b1, 3'd0, 16'h0110);

`ifdef RR_SWITCH_FORCE_EN
    force_en = 1'b1;
    force_sel = 3'd3;
    for (int i = 0; i < 3; i++)
      step($sformatf("force%0d", i), 8'hFF, 1'b1, 8'h08, 1'b1, 3'd3, 16'h0440);
    force_en = 1'b0;
    step("force_ptr", 8'hFF, 1'b1, 8'h02, 1'b1, 3'd1, 16'h0220);
    force_en = 1'b1;
    step("force_noreq", 8'hF7, 1'b1, 8'h00, 1'b0, 3'd1, 16'h0220);
    force_en = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
